// File: rtl/rc_decode_arbiter.sv
// Round-robin burst arbiter feeding one decoder stream from NREQ accumulators.
// Define RC_ARB_STAT_EN to add the oBeats output-handshake counter.
module rc_decode_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [NREQ-1:0]         iValid_AS,
    output logic [NREQ-1:0]         oReady_AS,
    input  logic [NREQ*WIDTH-1:0]   iData_AS,
    output logic                    oValid_BM,
    input  logic                    iReady_BM,
    output logic [WIDTH-1:0]        oData_BM,
    output logic [$clog2(NREQ)-1:0] oSrc,
    output logic [NREQ-1:0]         oGrant
`ifdef RC_ARB_STAT_EN
    ,
    output logic [31:0]             oBeats
`endif
);

    localparam int SW = $clog2(NREQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state, stateNext;
    logic [SW-1:0] ptr, ptrNext;
    logic [SW-1:0] g, gNext;
    logic [CW-1:0] cnt, cntNext;
    logic [SW-1:0] pick;
    logic          found;
    logic          slotFree;
    logic          accept;
    logic          lastBeat;

    // Output slot can take a new beat if empty or draining this cycle
    assign slotFree = ~oValid_BM | iReady_BM;
    assign accept   = (state == BUSY) & iValid_AS[g] & slotFree;
    assign lastBeat = (cnt == CW'(BURST_LEN - 1));

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && iValid_AS[(int'(ptr) + i) % NREQ]) begin
                found = 1'b1;
                pick  = SW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    always_comb begin
        oReady_AS = '0;
        oGrant    = '0;
        if (state == BUSY) begin
            oReady_AS[g] = slotFree;
            oGrant[g]    = 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        gNext     = g;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    gNext     = pick;
                    cntNext   = '0;
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                if (accept) begin
                    cntNext = cnt + CW'(1);
                    if (lastBeat) begin
                        stateNext = IDLE;
                        ptrNext   = g;
                    end
                end else if (!iValid_AS[g]) begin
                    stateNext = IDLE;
                    ptrNext   = g;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
            ptr   <= SW'(NREQ - 1);
            g     <= '0;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
            g     <= gNext;
            cnt   <= cntNext;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oValid_BM <= 1'b0;
            oData_BM  <= '0;
            oSrc      <= '0;
        end else if (accept) begin
            oValid_BM <= 1'b1;
            oData_BM  <= iData_AS[int'(g)*WIDTH +: WIDTH];
            oSrc      <= g;
        end else if (iReady_BM) begin
            oValid_BM <= 1'b0;
        end
    end

`ifdef RC_ARB_STAT_EN
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oBeats <= '0;
        end else if (oValid_BM && iReady_BM) begin
            oBeats <= oBeats + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rc_decode_arbiter.sv
// Directed bench for rc_decode_arbiter (NREQ=4, WIDTH=8, BURST_LEN=2).
module tb_rc_decode_arbiter;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [3:0]  iValid_AS;
    logic [3:0]  oReady_AS;
    logic [31:0] iData_AS;
    logic        oValid_BM;
    logic        iReady_BM;
    logic [7:0]  oData_BM;
    logic [1:0]  oSrc;
    logic [3:0]  oGrant;
`ifdef RC_ARB_STAT_EN
    logic [31:0] oBeats;
`endif

    rc_decode_arbiter #(.NREQ(4), .WIDTH(8), .BURST_LEN(2)) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iValid_AS (iValid_AS),
        .oReady_AS (oReady_AS),
        .iData_AS  (iData_AS),
        .oValid_BM (oValid_BM),
        .iReady_BM (iReady_BM),
        .oData_BM  (oData_BM),
        .oSrc      (oSrc),
        .oGrant    (oGrant)
`ifdef RC_ARB_STAT_EN
        ,
        .oBeats    (oBeats)
`endif
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic        r;
        logic        eV;
        logic [7:0]  eD;
        logic [1:0]  eS;
        logic [3:0]  eG;
        logic [3:0]  eR;
    } vec_t;

    vec_t vecs[24];
    int   nAssert = 0;
    int   nFail   = 0;
    int   seq[4];
    int   hsCount;
    logic [1:0] hsSrc[16];
    logic [7:0] hsData[16];
    logic [1:0] expSrc[10]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [7:0] expData[10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20,
                                8'h21, 8'h30, 8'h31, 8'h02, 8'h03};

    function automatic vec_t mk(logic rst, logic [3:0] v, logic [31:0] d,
                                logic r, logic eV, logic [7:0] eD,
                                logic [1:0] eS, logic [3:0] eG, logic [3:0] eR);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.r = r;
        t.eV = eV; t.eD = eD; t.eS = eS; t.eG = eG; t.eR = eR;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic doReset();
        iRST      = 1'b1;
        iValid_AS = '0;
        @(posedge iCLK);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
    endtask

    // All four requesters always valid; each counts its own accepted beats
    task automatic runStream(input int n);
        int cyc;
        logic [3:0] acc;
        cyc     = 0;
        hsCount = 0;
        while (hsCount < n && cyc < 100) begin
            iValid_AS = 4'hF;
            for (int r = 0; r < 4; r++)
                iData_AS[r*8 +: 8] = 8'((r << 4) | seq[r]);
            @(negedge iCLK);
            if (oValid_BM && iReady_BM) begin
                hsSrc[hsCount]  = oSrc;
                hsData[hsCount] = oData_BM;
                hsCount++;
            end
            acc = iValid_AS & oReady_AS;
            cyc++;
            if (hsCount < n) begin
                @(posedge iCLK);
                #1;
                for (int r = 0; r < 4; r++)
                    if (acc[r]) seq[r]++;
            end
        end
        if (hsCount < n) chk("streamTimeout", 32'(hsCount), 32'(n));
    endtask

    initial begin
        // single requester bursts with release gap
        vecs[0]  = mk(1, 4'b0010, 32'h0000_1100, 1, 0, 8'h00, 0, 4'b0000, 4'b0000);
        vecs[1]  = mk(0, 4'b0010, 32'h0000_1100, 1, 0, 8'h00, 0, 4'b0010, 4'b0010);
        vecs[2]  = mk(0, 4'b0010, 32'h0000_2200, 1, 1, 8'h11, 1, 4'b0010, 4'b0010);
        vecs[3]  = mk(0, 4'b0010, 32'h0000_3300, 1, 1, 8'h22, 1, 4'b0000, 4'b0000);
        vecs[4]  = mk(0, 4'b0010, 32'h0000_3300, 1, 0, 8'h22, 1, 4'b0010, 4'b0010);
        vecs[5]  = mk(0, 4'b0000, 32'h0000_0000, 1, 1, 8'h33, 1, 4'b0010, 4'b0010);
        vecs[6]  = mk(0, 4'b0000, 32'h0000_0000, 1, 0, 8'h33, 1, 4'b0000, 4'b0000);
        // downstream stall for five cycles
        vecs[7]  = mk(0, 4'b0001, 32'h0000_00A0, 1, 0, 8'h33, 1, 4'b0000, 4'b0000);
        vecs[8]  = mk(0, 4'b0001, 32'h0000_00A0, 1, 0, 8'h33, 1, 4'b0001, 4'b0001);
        vecs[9]  = mk(0, 4'b0001, 32'h0000_00A1, 0, 1, 8'hA0, 0, 4'b0001, 4'b0000);
        vecs[10] = mk(0, 4'b0001, 32'h0000_00A1, 0, 1, 8'hA0, 0, 4'b0001, 4'b0000);
        vecs[11] = mk(0, 4'b0001, 32'h0000_00A1, 0, 1, 8'hA0, 0, 4'b0001, 4'b0000);
        vecs[12] = mk(0, 4'b0001, 32'h0000_00A1, 0, 1, 8'hA0, 0, 4'b0001, 4'b0000);
        vecs[13] = mk(0, 4'b0001, 32'h0000_00A1, 0, 1, 8'hA0, 0, 4'b0001, 4'b0000);
        vecs[14] = mk(0, 4'b0001, 32'h0000_00A1, 1, 1, 8'hA0, 0, 4'b0001, 4'b0001);
        vecs[15] = mk(0, 4'b0000, 32'h0000_0000, 1, 1, 8'hA1, 0, 4'b0000, 4'b0000);
        vecs[16] = mk(0, 4'b0000, 32'h0000_0000, 1, 0, 8'hA1, 0, 4'b0000, 4'b0000);
        // requester 2 drops early, requester 3 follows
        vecs[17] = mk(1, 4'b1100, 32'hD0C0_0000, 1, 0, 8'h00, 0, 4'b0000, 4'b0000);
        vecs[18] = mk(0, 4'b1100, 32'hD0C0_0000, 1, 0, 8'h00, 0, 4'b0100, 4'b0100);
        vecs[19] = mk(0, 4'b1000, 32'hD000_0000, 1, 1, 8'hC0, 2, 4'b0100, 4'b0100);
        vecs[20] = mk(0, 4'b1000, 32'hD000_0000, 1, 0, 8'hC0, 2, 4'b0000, 4'b0000);
        vecs[21] = mk(0, 4'b1000, 32'hD000_0000, 1, 0, 8'hC0, 2, 4'b1000, 4'b1000);
        vecs[22] = mk(0, 4'b0000, 32'h0000_0000, 1, 1, 8'hD0, 3, 4'b1000, 4'b1000);
        vecs[23] = mk(0, 4'b0000, 32'h0000_0000, 1, 0, 8'hD0, 3, 4'b0000, 4'b0000);

        // everything quiet while reset is held, even with all requesters valid
        iRST      = 1'b1;
        iValid_AS = 4'hF;
        iData_AS  = 32'hFFFF_FFFF;
        iReady_BM = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge iCLK);
            chk($sformatf("rstValid%0d", c), 32'(oValid_BM), 32'h0);
            chk($sformatf("rstData%0d", c), 32'(oData_BM), 32'h0);
            chk($sformatf("rstSrc%0d", c), 32'(oSrc), 32'h0);
            chk($sformatf("rstGrant%0d", c), 32'(oGrant), 32'h0);
            chk($sformatf("rstReady%0d", c), 32'(oReady_AS), 32'h0);
        end
        @(posedge iCLK);
        #1;
        iValid_AS = '0;
        iRST      = 1'b0;

        for (int i = 0; i < 24; i++) begin
            if (vecs[i].rst) doReset();
            iValid_AS = vecs[i].v;
            iData_AS  = vecs[i].d;
            iReady_BM = vecs[i].r;
            @(negedge iCLK);
            chk($sformatf("vec%0d{v,d,s,g,r}", i),
                32'({oValid_BM, oData_BM, oSrc, oGrant, oReady_AS}),
                32'({vecs[i].eV, vecs[i].eD, vecs[i].eS, vecs[i].eG, vecs[i].eR}));
            @(posedge iCLK);
            #1;
        end

        // round robin with all requesters valid
        iReady_BM = 1'b1;
        doReset();
        for (int r = 0; r < 4; r++) seq[r] = 0;
        runStream(10);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("rrSrc%0d", k), 32'(hsSrc[k]), 32'(expSrc[k]));
            chk($sformatf("rrData%0d", k), 32'(hsData[k]), 32'(expData[k]));
        end
`ifdef RC_ARB_STAT_EN
        @(posedge iCLK);
        #1;
        chk("beats10", oBeats, 32'd10);
`endif

        // reset in the middle of requester 2's burst
        doReset();
        for (int r = 0; r < 4; r++) seq[r] = 0;
        runStream(5);
        chk("midGrant", 32'(oGrant), 32'h4);
        chk("midSrc", 32'(hsSrc[4]), 32'h2);
`ifdef RC_ARB_STAT_EN
        chk("beats4", oBeats, 32'd4);
`endif
        iRST = 1'b1;
        #1;
        chk("midRstValid", 32'(oValid_BM), 32'h0);
        chk("midRstGrant", 32'(oGrant), 32'h0);
        chk("midRstReady", 32'(oReady_AS), 32'h0);
        chk("midRstData", 32'(oData_BM), 32'h0);
`ifdef RC_ARB_STAT_EN
        chk("midRstBeats", oBeats, 32'd0);
`endif
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        runStream(1);
        chk("postRstSrc", 32'(hsSrc[0]), 32'h0);
        chk("postRstData", 32'(hsData[0]), 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/rc_decode_arbiter.md
RC_DECODE_ARBITER -- requirements
Module: rc_decode_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of accumulator requesters sharing one decoder input stream; legal range 2..16.
REQ-002 Parameter WIDTH, default 32: data width per requester beat.
REQ-003 Parameter BURST_LEN, default 4: maximum consecutive beats granted to one requester before re-arbitration; legal range is at least 1.
REQ-004 Port iCLK, input, 1: the only clock; all state on rising edge.
REQ-005 Port iRST, input, 1: reset, asynchronous and active-high.
REQ-006 Port iValid_AS, input, NREQ: per-requester beat valid.
REQ-007 Port oReady_AS, output, NREQ: per-requester beat ready.
REQ-008 Port iData_AS, input, NREQ*WIDTH: requester r data in bits [r*WIDTH +: WIDTH].
REQ-009 Port oValid_BM, output, 1: registered output beat valid, toward the decoder.
REQ-010 Port iReady_BM, input, 1: decoder ready.
REQ-011 Port oData_BM, output, WIDTH: registered output beat data.
REQ-012 Port oSrc, output, $clog2(NREQ): requester index of the beat in oData_BM, registered with the data.
REQ-013 Port oGrant, output, NREQ: one-hot current grant; all zero in IDLE.

Function
REQ-014 FSM states are IDLE and BUSY only.
REQ-015 IDLE: if any iValid_AS bit is set, grant the first set bit searching round-robin from ptr+1 (mod NREQ), load grant index g, clear the beat counter, and go to BUSY; no beat is accepted in IDLE.
REQ-016 BUSY: oReady_AS[g] = (~oValid_BM | iReady_BM); every other oReady_AS bit is 0.
REQ-017 A beat is accepted when iValid_AS[g] & oReady_AS[g]; on accept, oData_BM <= iData_AS[g], oSrc <= g, oValid_BM <= 1, and the beat counter increments.
REQ-018 oValid_BM clears when iReady_BM=1 and no beat is accepted in the same cycle; oData_BM and oSrc stay stable while oValid_BM=1 and iReady_BM=0.
REQ-019 Latency is exactly 1 cycle from accept to oValid_BM; throughput is 1 beat/cycle within a burst while iReady_BM=1.
REQ-020 Release to IDLE with ptr <= g happens when a beat is accepted with beat counter = BURST_LEN-1, or when iValid_AS[g]=0 in BUSY (no beat accepted in that cycle).
REQ-021 The beat counter width is $clog2(BURST_LEN+1); it never wraps within a burst.
REQ-022 A requester that deasserts valid while not granted is not tracked and loses no state.
REQ-023 oGrant equals the one-hot of g in BUSY and 0 in IDLE.

Reset
REQ-024 While iRST=1: state=IDLE, ptr=NREQ-1, counter=0, oValid_BM=0, oData_BM=0, oSrc=0, oGrant=0, oReady_AS=0.
REQ-025 Reset asserted mid-burst discards the registered output beat and the grant; after release, the first arbitration starts from requester 0.

Configuration
REQ-026 Macro RC_ARB_STAT_EN, when defined, adds output port oBeats (32 bits): the count of output handshakes (oValid_BM & iReady_BM), cleared by reset, wrapping modulo 2^32.
REQ-027 Without RC_ARB_STAT_EN, port oBeats and its counter are absent, and all other behaviour is identical.

Verification (NREQ=4, WIDTH=8, BURST_LEN=2)
REQ-028 All iValid_AS=4'hF during iRST=1 -> every output stays 0, with no accept.
REQ-029 Requester 1 offers 0x11, 0x22, 0x33 with iReady_BM=1 -> the first grant comes after one IDLE cycle; 0x11 and 0x22 appear with oSrc=1 on consecutive cycles; release; a one-cycle gap; then 0x33.
REQ-030 All four valid continuously with iReady_BM=1 -> the oSrc sequence is 0,0,1,1,2,2,3,3,0,0.
REQ-031 iReady_BM=0 for 5 cycles while oValid_BM=1 -> oData_BM and oSrc hold, oReady_AS=0, and no beat is lost or duplicated.
REQ-032 Requester 2 drops valid after 1 beat while requester 3 is valid -> release with ptr=2; requester 3 is granted next.
REQ-033 With RC_ARB_STAT_EN, after 10 output handshakes oBeats=10; iRST pulsed mid-burst -> oBeats=0 and the next beat comes from requester 0.
